sort_loader: RTL and testbench
==============================

Name: sort_loader

Overview:
- Serial-to-parallel input stage placed directly upstream of the combinational bubble_sort.
- Accepts array elements one per cycle over a valid/ready stream and packs DIM of them into the flat DIM*WIDTH vector the sorter consumes.
- Holds that vector stable, with out_valid, until the consumer has taken the sorted result.
- Short bursts terminated by in_last are padded so that pad slots sort to the top.

Parameters:
DIM, 4, number of elements per packed array (>= 2)
WIDTH, 8, bits per element
PAD, {WIDTH{1'b1}}, value written into unfilled slots (maximum, so pads sort last)

Ports:
clk  in  1  clock, all state on rising edge
rst_n  in  1  asynchronous active-low reset
in_data  in  WIDTH  element to load
in_valid  in  1  in_data valid
in_last  in  1  qualifies in_data as final element of a short burst
in_ready  out  1  loader can accept an element this cycle
out_data  out  DIM*WIDTH  packed array; element i at bits [WIDTH*(i+1)-1 : WIDTH*i], feeds sorter input
out_count  out  $clog2(DIM+1)  number of real (non-pad) elements in out_data, 1..DIM
out_valid  out  1  out_data complete and stable
out_ready  in  1  consumer has taken the sorted result

Behaviour:
- Reset (rst_n low, asynchronous): state=FILL, idx=0, every slot=PAD, out_count=0, out_valid=0. in_ready is gated to 0 while rst_n is low and rises in the first cycle after release.
- States: FILL (collecting), FULL (presenting).
- FILL:
  - in_ready=1, out_valid=0.
  - Accept = in_valid & in_ready: slot[idx] <= in_data, idx <= idx+1.
  - If the accept has idx==DIM-1, or in_last=1: go to FULL, out_count <= idx+1. Remaining slots keep PAD.
  - in_last on slot DIM-1 is identical to a normal full fill.
- FULL:
  - in_ready=0, out_valid=1.
  - out_data and out_count held constant; in_valid and in_last are ignored.
  - On out_valid & out_ready: go to FILL, idx <= 0, all slots <= PAD, out_count <= 0.
- No bypass: an element cannot be accepted in the same cycle as the out_ready handshake. Minimum period is DIM+1 cycles per full array.
- Latency: out_valid rises the cycle after the final accepted element. The sorted result is valid combinationally from that same cycle.
- out_ready while out_valid=0 has no effect.
- in_valid is not required to be continuous. Bubbles leave idx and slots unchanged.
- idx width is $clog2(DIM). It never wraps, because FULL is entered at DIM-1.
- out_data is driven directly from the slot registers, so it changes only on clock edges.
- Reset asserted mid-fill or in FULL discards the partial or pending array immediately. No output handshake follows.

Test Plan:
- DIM=4, WIDTH=8: stream 0x37,0x02,0xC8,0x15 back-to-back with out_ready=0 -> out_valid=1 on the cycle after the 4th accept; out_data=0x15C80237; out_count=4; in_ready=0; values held for 10 cycles. Then pulse out_ready -> next cycle out_valid=0, in_ready=1, out_data=0xFFFFFFFF.
- Short burst 0x10, then 0x05 with in_last=1 -> out_data=0xFFFF0510, out_count=2; downstream sort yields 0x05,0x10,0xFF,0xFF.
- in_valid toggled 1,0,0,1,1,0,1 carrying 0xAA,x,x,0xBB,0xCC,x,0xDD -> out_data=0xDDCCBBAA after the 7th cycle; out_count=4.
- Drive in_valid=1 with 0x99 continuously while in FULL -> no slot changes. After the out_ready handshake, 0x99 is accepted into slot 0 on the following cycle, not the handshake cycle.
- Drop rst_n for one cycle after 2 of 4 elements are loaded -> out_valid=0 and out_data=all PAD immediately. A fresh 4-element load then produces a correct array with out_count=4.
- Single element 0x00 with in_last=1 -> out_count=1, out_data=0xFFFFFF00.

Source files
------------

// File: rtl/sort_loader.sv
// sort_loader: serial-to-parallel packer that feeds a combinational sorter.
// Elements arrive one per cycle over valid/ready. DIM of them are packed
// into a flat vector that is held stable until the consumer takes the sorted
// result. A burst cut short by in_last leaves its unused slots at PAD, so
// those slots sort to the top.
module sort_loader #(
    parameter int                 DIM   = 4,
    parameter int                 WIDTH = 8,
    parameter logic [WIDTH-1:0]   PAD   = {WIDTH{1'b1}}
) (
    input  logic                       clk,
    input  logic                       rst_n,
    input  logic [WIDTH-1:0]           in_data,
    input  logic                       in_valid,
    input  logic                       in_last,
    output logic                       in_ready,
    output logic [DIM*WIDTH-1:0]       out_data,
    output logic [$clog2(DIM+1)-1:0]   out_count,
    output logic                       out_valid,
    input  logic                       out_ready
);

    localparam int IDX_W = $clog2(DIM);
    localparam int CNT_W = $clog2(DIM+1);

    typedef enum logic {FILL = 1'b0, FULL = 1'b1} state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q,   idx_d;
    logic [CNT_W-1:0]   cnt_q,   cnt_d;
    logic [WIDTH-1:0]   slot_q [DIM];
    logic [WIDTH-1:0]   slot_d [DIM];

    // in_ready is forced low while reset is held; only FILL accepts elements.
    assign in_ready  = rst_n & (state_q == FILL);
    assign out_valid = (state_q == FULL);
    assign out_count = cnt_q;

    // Pack the slot registers into the flat vector; element i sits in lane i.
    always_comb begin
        out_data = '0;
        for (int i = 0; i < DIM; i++) begin
            out_data[WIDTH*i +: WIDTH] = slot_q[i];
        end
    end

    // Next-state logic: fill slots one at a time, then present until taken.
    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        cnt_d   = cnt_q;
        for (int i = 0; i < DIM; i++) begin
            slot_d[i] = slot_q[i];
        end

        unique case (state_q)
            FILL: begin
                if (in_valid) begin
                    slot_d[idx_q] = in_data;
                    if ((idx_q == IDX_W'(DIM-1)) || in_last) begin
                        // idx is left alone here so it never wraps; it is
                        // cleared when the array is released.
                        state_d = FULL;
                        cnt_d   = CNT_W'(idx_q) + CNT_W'(1);
                    end else begin
                        idx_d   = idx_q + IDX_W'(1);
                    end
                end
            end
            FULL: begin
                // No bypass: the cycle that releases the array accepts nothing.
                if (out_ready) begin
                    state_d = FILL;
                    idx_d   = '0;
                    cnt_d   = '0;
                    for (int i = 0; i < DIM; i++) begin
                        slot_d[i] = PAD;
                    end
                end
            end
            default: state_d = FILL;
        endcase
    end

    // State, index, count and slot registers; reset discards any partial array.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= FILL;
            idx_q   <= '0;
            cnt_q   <= '0;
            for (int i = 0; i < DIM; i++) begin
                slot_q[i] <= PAD;
            end
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            cnt_q   <= cnt_d;
            for (int i = 0; i < DIM; i++) begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

endmodule

// File: tb/tb_sort_loader.sv
// Directed bench for sort_loader (DIM=4, WIDTH=8) with an expected-result
// queue filled when an array's last element is driven and drained when the
// loader presents it.
module tb_sort_loader;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [7:0]  in_data;
    logic        in_valid;
    logic        in_last;
    logic        in_ready;
    logic [31:0] out_data;
    logic [2:0]  out_count;
    logic        out_valid;
    logic        out_ready;

    typedef struct packed {
        logic [31:0] data;
        logic [2:0]  cnt;
    } exp_t;

    exp_t sb[$];
    int   errors = 0;
    int   checks = 0;

    sort_loader #(.DIM(4), .WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_data   (in_data),
        .in_valid  (in_valid),
        .in_last   (in_last),
        .in_ready  (in_ready),
        .out_data  (out_data),
        .out_count (out_count),
        .out_valid (out_valid),
        .out_ready (out_ready)
    );

    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic send(input logic [7:0] d, input logic last);
        in_valid = 1'b1;
        in_data  = d;
        in_last  = last;
        tick();
        in_valid = 1'b0;
        in_last  = 1'b0;
    endtask

    // Wait (bounded) for a presented array and compare it with the queue head.
    task automatic expect_out(input string tag);
        exp_t e;
        int   n = 0;
        while (out_valid !== 1'b1 && n < 20) begin
            tick();
            n++;
        end
        chk({tag, "_valid"}, 32'(out_valid), 32'd1);
        if (out_valid === 1'b1) begin
            if (sb.size() == 0) begin
                chk({tag, "_unexpected"}, 32'd1, 32'd0);
            end else begin
                e = sb.pop_front();
                chk({tag, "_data"},  out_data,         e.data);
                chk({tag, "_count"}, 32'(out_count),   32'(e.cnt));
                chk({tag, "_ready"}, 32'(in_ready),    32'd0);
            end
        end
    endtask

    task automatic consume(input string tag);
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk({tag, "_rel_valid"}, 32'(out_valid), 32'd0);
        chk({tag, "_rel_ready"}, 32'(in_ready),  32'd1);
        chk({tag, "_rel_pad"},   out_data,       32'hFFFF_FFFF);
        chk({tag, "_rel_cnt"},   32'(out_count), 32'd0);
    endtask

    initial begin
        logic [7:0]  vals [7];
        logic        vlds [7];
        logic [31:0] held;

        rst_n     = 1'b0;
        in_data   = '0;
        in_valid  = 1'b0;
        in_last   = 1'b0;
        out_ready = 1'b0;
        #12;
        chk("rst_ready", 32'(in_ready),  32'd0);
        chk("rst_valid", 32'(out_valid), 32'd0);
        chk("rst_data",  out_data,       32'hFFFF_FFFF);
        chk("rst_count", 32'(out_count), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        chk("post_rst_ready", 32'(in_ready), 32'd1);

        // Full back-to-back fill, then hold for 10 cycles.
        send(8'h37, 1'b0);
        send(8'h02, 1'b0);
        send(8'hC8, 1'b0);
        chk("t1_not_early", 32'(out_valid), 32'd0);
        sb.push_back('{32'h15C8_0237, 3'd4});
        send(8'h15, 1'b0);
        chk("t1_latency", 32'(out_valid), 32'd1);
        expect_out("t1");
        for (int i = 0; i < 10; i++) begin
            tick();
            chk("t1_hold_data",  out_data,       32'h15C8_0237);
            chk("t1_hold_valid", 32'(out_valid), 32'd1);
        end
        consume("t1");

        // Short burst terminated by in_last.
        send(8'h10, 1'b0);
        sb.push_back('{32'hFFFF_0510, 3'd2});
        send(8'h05, 1'b1);
        expect_out("t2");
        consume("t2");

        // Bubbly input; out_ready during FILL must be ignored.
        vals = '{8'hAA, 8'h00, 8'h00, 8'hBB, 8'hCC, 8'h00, 8'hDD};
        vlds = '{1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1};
        sb.push_back('{32'hDDCC_BBAA, 3'd4});
        for (int i = 0; i < 7; i++) begin
            in_valid  = vlds[i];
            in_data   = vals[i];
            out_ready = (i == 2);
            tick();
            if (i == 5) chk("t3_partial", out_data, 32'hFFCC_BBAA);
        end
        in_valid  = 1'b0;
        out_ready = 1'b0;
        chk("t3_latency", 32'(out_valid), 32'd1);
        expect_out("t3");
        consume("t3");

        // Input held valid while FULL; no bypass on the release cycle.
        send(8'h01, 1'b0);
        send(8'h02, 1'b0);
        send(8'h03, 1'b0);
        sb.push_back('{32'h0403_0201, 3'd4});
        send(8'h04, 1'b0);
        expect_out("t4");
        in_valid = 1'b1;
        in_data  = 8'h99;
        held     = out_data;
        for (int i = 0; i < 3; i++) begin
            tick();
            chk("t4_full_hold", out_data, held);
        end
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        chk("t4_no_bypass", out_data,      32'hFFFF_FFFF);
        chk("t4_rel_ready", 32'(in_ready), 32'd1);
        tick();
        in_valid = 1'b0;
        chk("t4_slot0", out_data, 32'hFFFF_FF99);
        sb.push_back('{32'hFFFF_8899, 3'd2});
        send(8'h88, 1'b1);
        expect_out("t4b");
        consume("t4b");

        // Reset mid-fill discards the partial array.
        send(8'hA1, 1'b0);
        send(8'hA2, 1'b0);
        rst_n = 1'b0;
        #1;
        chk("t5_rst_valid", 32'(out_valid), 32'd0);
        chk("t5_rst_data",  out_data,       32'hFFFF_FFFF);
        chk("t5_rst_ready", 32'(in_ready),  32'd0);
        tick();
        rst_n = 1'b1;
        tick();
        send(8'h11, 1'b0);
        send(8'h22, 1'b0);
        send(8'h33, 1'b0);
        sb.push_back('{32'h4433_2211, 3'd4});
        send(8'h44, 1'b0);
        expect_out("t5");
        consume("t5");

        // Single element burst.
        sb.push_back('{32'hFFFF_FF00, 3'd1});
        send(8'h00, 1'b1);
        expect_out("t6");
        consume("t6");

        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
